uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer between the UART receiver and the host/consumer logic. It captures every completed character (`rx_data` on `rx_done_tick`) together with that character's parity-error status into a circular FIFO. It presents the oldest entry first-word-fall-through to the consumer and flags overflow stickily. It lets the consumer drain characters at its own pace without losing the one-cycle receiver pulses.

## Interface
Parameters:
- `DATA_BITS`, 8, character width; must match the receiver.
- `ADDR_BITS`, 3, log2 of FIFO depth; depth = 2**ADDR_BITS (default 8 entries); legal range 1..8.

Ports:
- `clk`  in  1  system clock; the single clock, shared with the receiver.
- `reset`  in  1  reset, synchronous and active-high.
- `rx_data`  in  DATA_BITS  received character from the receiver.
- `rx_done_tick`  in  1  one-cycle pulse; `rx_data` is valid in this cycle.
- `parity_err`  in  1  one-cycle pulse from the receiver; it occurs during the parity bit, before `rx_done_tick`.
- `rd_en`  in  1  consumer pop request; ignored while `empty`.
- `clr_overflow`  in  1  one-cycle clear of the sticky `overflow` flag.
- `rd_data`  out  DATA_BITS  head entry data; valid whenever `empty`=0.
- `rd_perr`  out  1  parity-error tag of the head entry; valid whenever `empty`=0.
- `empty`  out  1  FIFO holds zero entries.
- `full`  out  1  FIFO holds 2**ADDR_BITS entries.
- `count`  out  ADDR_BITS+1  current number of entries.
- `overflow`  out  1  sticky; set when a character is dropped.

## Operation
Parity capture:
- `perr_pend` register is set on `parity_err`=1.
- Entry tag = `perr_pend | parity_err` sampled at `rx_done_tick`. This covers a same-cycle pulse.
- `perr_pend` clears on every `rx_done_tick`, whether the write is accepted or dropped.
- If `parity_err` and `rx_done_tick` occur in the same cycle, the tag is 1 and `perr_pend` ends at 0.

Write rules:
- A write is attempted on `rx_done_tick`.
- Accepted if `full`=0, or if `full`=1 and a valid pop (`rd_en`) occurs in the same cycle.
- On acceptance, `{tag, rx_data}` is stored at `wr_ptr` and `wr_ptr` increments.

Read rules:
- A pop is valid iff `rd_en`=1 and `empty`=0.
- A valid pop increments `rd_ptr`.
- `rd_data` and `rd_perr` are combinational from `mem[rd_ptr]`.

Pointers and count:
- `wr_ptr` and `rd_ptr` are ADDR_BITS wide and wrap modulo depth with no special case.
- `count` is a registered up/down counter:
  - +1 on accepted write only.
  - −1 on valid pop only.
  - Unchanged when both or neither occur.
- `empty` = (`count`==0); `full` = (`count`==2**ADDR_BITS). Both are decoded from the registered `count`.

Overflow:
- Dropped write (full, no same-cycle pop): storage and pointers are unchanged and `overflow` is set.
- `clr_overflow` clears `overflow`; a drop in the same cycle wins, so `overflow` stays 1.

Simultaneous events:
- Empty + write + `rd_en`: the pop is ignored, the write is accepted, and `count` becomes 1.
- Full + write + `rd_en`: both succeed and `count` stays full.

## Timing
- Reset (synchronous, at a `clk` edge with `reset`=1):
  - Pointers, `count`, `perr_pend` and `overflow` are set to 0.
  - Outputs: `empty`=1, `full`=0, `count`=0, `overflow`=0, `rd_perr`=0 (head tag is masked while empty), `rd_data`=0 while empty (masked).
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all entries and any pending parity flag.
  - Reset overrides every other input in the same cycle.
- Write latency: a character captured at edge N is visible on `rd_data` with `empty`=0 immediately after edge N (one cycle after the `rx_done_tick` cycle).
- Pop: with `rd_en` high in cycle N, the next entry (or `empty`=1) appears after edge N.
  - Back-to-back pops every cycle are supported.
- The path from input to any output flag is registered; there is no combinational path from `rd_en` or `rx_done_tick` to `empty`, `full` or `count`.

## Structure
- Shared UART package holds:
  - `DATA_BITS` default.
  - Entry type: a {perr, data} struct, width DATA_BITS+1.
  - Default FIFO `ADDR_BITS`.
- The tx-side FIFO reuses the same package.
- One sub-module, `uart_fifo_mem`: a 2**ADDR_BITS × (DATA_BITS+1) register array with 1 synchronous write port and 1 asynchronous read port.
- Control (pointers, count, flags, parity capture) stays in `uart_rx_fifo`.

## Test plan
- Reset, then 3 writes `0x41`, `0x42`, `0x43` with no parity pulses, then 3 pops -> reads `41`, `42`, `43` in order, `rd_perr`=0, `count` goes 3→0, `empty`=1.
- `parity_err` pulse 5 cycles before the `rx_done_tick` carrying `0x55`, then a clean `0xAA` -> `rd_perr`=1 for `55`, 0 for `AA`.
- `parity_err` in the same cycle as `rx_done_tick` -> tag=1.
- Fill 8 entries (`0x00`–`0x07`), then a 9th write `0xFF` -> `full`=1, `overflow`=1, and reads return `00`–`07` with no `FF`.
- `clr_overflow` -> `overflow`=0.
- Full, then write `0x80` with `rd_en` in the same cycle -> `00` popped, `80` stored, `count` stays 8, `overflow` stays 0.
- Empty, then write `0x11` with `rd_en` in the same cycle -> `count`=1 and `rd_data`=`11`.
- Drive 20 writes with interleaved pops so the pointers wrap twice -> data order is preserved.
- Assert `reset` with 4 entries stored -> `empty`=1, `count`=0, `overflow`=0 after the edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: character width, default FIFO depth and the
// {perr, data} FIFO entry layout used by both rx and tx buffers.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int FIFO_ADDR_BITS = 3;

    typedef struct packed {
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem #(
    parameter int WIDTH     = uart_pkg::DATA_BITS + 1,
    parameter int ADDR_BITS = uart_pkg::FIFO_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: captures each received character with its parity-error tag,
// presents the oldest entry first-word-fall-through, and flags drops stickily.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = uart_pkg::DATA_BITS,
    parameter int ADDR_BITS = uart_pkg::FIFO_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_done_tick,
    input  logic                 parity_err,
    input  logic                 rd_en,
    input  logic                 clr_overflow,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow
);

    // Local copy of the package entry layout so DATA_BITS may be overridden.
    typedef struct packed {
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(2**ADDR_BITS);

    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]   count_r;
    logic                 perr_pend;
    logic                 overflow_r;
    logic                 pop, wr_ok;
    entry_t               wr_entry, head;

    assign empty = (count_r == '0);
    assign full  = (count_r == DEPTH);
    assign count = count_r;
    assign overflow = overflow_r;

    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign pop   = rd_en && !empty;
    assign wr_ok = rx_done_tick && (!full || pop);

    assign wr_entry.perr = perr_pend | parity_err;
    assign wr_entry.data = rx_data;

    uart_fifo_mem #(
        .WIDTH     ($bits(entry_t)),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head is masked while empty so stale storage never leaks out.
    assign rd_data = empty ? '0 : head.data;
    assign rd_perr = empty ? 1'b0 : head.perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            perr_pend  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_BITS'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_BITS'(1);

            case ({wr_ok, pop})
                2'b10:   count_r <= count_r + (ADDR_BITS+1)'(1);
                2'b01:   count_r <= count_r - (ADDR_BITS+1)'(1);
                default: count_r <= count_r;
            endcase

            // The pending flag belongs to the character being completed.
            if (rx_done_tick)    perr_pend <= 1'b0;
            else if (parity_err) perr_pend <= 1'b1;

            // A drop in the same cycle as a clear keeps the flag set.
            if (rx_done_tick && !wr_ok) overflow_r <= 1'b1;
            else if (clr_overflow)      overflow_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default 8-bit, 8-deep).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       parity_err;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo #(.DATA_BITS(8), .ADDR_BITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after an edge, then sample 1 ns after the next edge.
    task automatic cyc(input logic rx, input logic [7:0] d, input logic pe,
                       input logic rd, input logic clr, input logic rst);
        rx_done_tick = rx; rx_data = d; parity_err = pe;
        rd_en = rd; clr_overflow = clr; reset = rst;
        @(posedge clk); #1;
        rx_done_tick = 0; rx_data = 8'h00; parity_err = 0;
        rd_en = 0; clr_overflow = 0; reset = 0;
    endtask

    task automatic test_reset();
        cyc(0, 8'h00, 0, 0, 0, 1);
        n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (count !== 4'd0)    begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (rd_perr !== 1'b0)  begin n_err++; $display("FAIL reset_rd_perr got=%b exp=0", rd_perr); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        cyc(1, 8'h41, 0, 0, 0, 0);
        n_cmp++; if (empty !== 1'b0 || rd_data !== 8'h41) begin n_err++; $display("FAIL basic_fwft got=%h/%b exp=41/0", rd_data, empty); end
        cyc(1, 8'h42, 0, 0, 0, 0);
        cyc(1, 8'h43, 0, 0, 0, 0);
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            exp = 8'h41 + 8'(i);
            n_cmp++; if (rd_data !== exp || rd_perr !== 1'b0) begin n_err++; $display("FAIL basic_read%0d got=%h/%b exp=%h/0", i, rd_data, rd_perr, exp); end
            n_cmp++; if (count !== 4'(3 - i)) begin n_err++; $display("FAIL basic_count_dn%0d got=%0d exp=%0d", i, count, 3 - i); end
            cyc(0, 8'h00, 0, 1, 0, 0);
        end
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL basic_drained got=%0d/%b exp=0/1", count, empty); end
    endtask

    task automatic test_parity();
        cyc(0, 8'h00, 1, 0, 0, 0);
        repeat (4) cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(1, 8'h55, 0, 0, 0, 0);
        cyc(1, 8'hAA, 0, 0, 0, 0);
        n_cmp++; if (rd_data !== 8'h55 || rd_perr !== 1'b1) begin n_err++; $display("FAIL parity_55 got=%h/%b exp=55/1", rd_data, rd_perr); end
        cyc(0, 8'h00, 0, 1, 0, 0);
        n_cmp++; if (rd_data !== 8'hAA || rd_perr !== 1'b0) begin n_err++; $display("FAIL parity_AA got=%h/%b exp=AA/0", rd_data, rd_perr); end
        cyc(0, 8'h00, 0, 1, 0, 0);
    endtask

    task automatic test_same_cycle_parity();
        cyc(1, 8'h33, 1, 0, 0, 0);
        cyc(1, 8'h34, 0, 0, 0, 0);
        n_cmp++; if (rd_data !== 8'h33 || rd_perr !== 1'b1) begin n_err++; $display("FAIL same_cyc_tag got=%h/%b exp=33/1", rd_data, rd_perr); end
        cyc(0, 8'h00, 0, 1, 0, 0);
        n_cmp++; if (rd_data !== 8'h34 || rd_perr !== 1'b0) begin n_err++; $display("FAIL same_cyc_pend_clr got=%h/%b exp=34/0", rd_data, rd_perr); end
        cyc(0, 8'h00, 0, 1, 0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0, 0, 0);
        n_cmp++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_full got=%b/%0d/%b exp=1/8/0", full, count, overflow); end
        cyc(1, 8'hFF, 0, 0, 0, 0);
        n_cmp++; if (overflow !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL ovf_drop got=%b/%0d exp=1/8", overflow, count); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rd_data !== 8'(i)) begin n_err++; $display("FAIL ovf_read%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            cyc(0, 8'h00, 0, 1, 0, 0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_no_ff got=%b exp=1", empty); end
        cyc(0, 8'h00, 0, 0, 1, 0);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0, 0, 0);
        cyc(1, 8'h80, 0, 1, 0, 0);
        n_cmp++; if (count !== 4'd8 || overflow !== 1'b0 || rd_data !== 8'h01) begin n_err++; $display("FAIL full_rw got=%0d/%b/%h exp=8/0/01", count, overflow, rd_data); end
        // Drop coinciding with a clear leaves the flag set.
        cyc(1, 8'h99, 0, 0, 1, 0);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_beats_clr got=%b exp=1", overflow); end
        cyc(0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 8'h80 : 8'(i + 1);
            n_cmp++; if (rd_data !== exp) begin n_err++; $display("FAIL full_rw_read%0d got=%h exp=%h", i, rd_data, exp); end
            cyc(0, 8'h00, 0, 1, 0, 0);
        end
        n_cmp++; if (empty !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL full_rw_end got=%b/%b exp=1/0", empty, overflow); end
    endtask

    task automatic test_empty_rw();
        cyc(1, 8'h11, 0, 1, 0, 0);
        n_cmp++; if (count !== 4'd1 || rd_data !== 8'h11) begin n_err++; $display("FAIL empty_rw got=%0d/%h exp=1/11", count, rd_data); end
        cyc(0, 8'h00, 0, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic rd;
        for (int i = 0; i < 20; i++) begin
            rd = (i % 4 != 3);
            if (rd && q.size() > 0) begin
                n_cmp++; if (rd_data !== q[0]) begin n_err++; $display("FAIL wrap_read%0d got=%h exp=%h", i, rd_data, q[0]); end
                void'(q.pop_front());
            end
            q.push_back(8'h60 + 8'(i));
            cyc(1, 8'h60 + 8'(i), 0, rd, 0, 0);
        end
        n_cmp++; if (count !== 4'(q.size())) begin n_err++; $display("FAIL wrap_count got=%0d exp=%0d", count, q.size()); end
        while (q.size() > 0) begin
            n_cmp++; if (rd_data !== q[0]) begin n_err++; $display("FAIL wrap_drain got=%h exp=%h", rd_data, q[0]); end
            void'(q.pop_front());
            cyc(0, 8'h00, 0, 1, 0, 0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(1, 8'hEE, 0, 0, 0, 1);
        n_cmp++; if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_mid got=%b/%0d/%b exp=1/0/0", empty, count, overflow); end
        cyc(1, 8'h21, 0, 0, 0, 0);
        n_cmp++; if (rd_data !== 8'h21 || rd_perr !== 1'b0) begin n_err++; $display("FAIL reset_mid_pend got=%h/%b exp=21/0", rd_data, rd_perr); end
    endtask

    initial begin
        reset = 1; rx_data = 0; rx_done_tick = 0; parity_err = 0; rd_en = 0; clr_overflow = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_parity();
        test_same_cycle_parity();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
